// File: rtl/kernel_run_ctrl.sv
// Run sequencer for an HLS kernel: synchronised trigger, counted or continuous
// ap_start/ap_ready/ap_done runs with idle gap, dataset stepping and per-run watchdog.
//   state | meaning
//   IDLE  | no campaign, waiting for a trigger rise with the kernel idle
//   RUN   | kernel invocation in flight, latency counting
//   GAP   | idle cycles with ap_start low between runs
module kernel_run_ctrl #(
  parameter int RUN_W          = 16,
  parameter int DATASET_NUM    = 8,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int DS_W  = (DATASET_NUM > 1) ? $clog2(DATASET_NUM) : 1,
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             trig,
  input  logic [RUN_W-1:0] run_count,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_idle,
  output logic [DS_W-1:0]  dataset_idx,
  output logic             ds_advance,
  output logic             busy,
  output logic [RUN_W-1:0] runs_done,
  output logic [31:0]      last_latency,
  output logic             timeout,
  output logic             campaign_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  localparam logic [31:0]     TO_LIM  = 32'(TIMEOUT_CYCLES);
  localparam logic [DS_W-1:0] DS_LAST = DS_W'(DATASET_NUM - 1);

  state_t state_q, state_d;
  logic trig_s1_q, trig_s2_q, trig_s3_q, rise;
  logic start_q, start_d, busy_q, busy_d, adv_q, adv_d, cdone_q, cdone_d, to_q, to_d;
  logic [RUN_W-1:0] cnt_q, cnt_d, runs_q, runs_d, runs_inc;
  logic [DS_W-1:0]  ds_q, ds_d;
  logic [31:0]      lat_q, lat_d, last_lat_q, last_lat_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  assign rise     = trig_s2_q & ~trig_s3_q;
  assign runs_inc = runs_q + 1'b1;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      trig_s1_q  <= 1'b0;
      trig_s2_q  <= 1'b0;
      trig_s3_q  <= 1'b0;
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      adv_q      <= 1'b0;
      cdone_q    <= 1'b0;
      to_q       <= 1'b0;
      cnt_q      <= '0;
      runs_q     <= '0;
      ds_q       <= '0;
      lat_q      <= '0;
      last_lat_q <= '0;
      gap_q      <= '0;
    end else begin
      trig_s1_q  <= trig;
      trig_s2_q  <= trig_s1_q;
      trig_s3_q  <= trig_s2_q;
      state_q    <= state_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      adv_q      <= adv_d;
      cdone_q    <= cdone_d;
      to_q       <= to_d;
      cnt_q      <= cnt_d;
      runs_q     <= runs_d;
      ds_q       <= ds_d;
      lat_q      <= lat_d;
      last_lat_q <= last_lat_d;
      gap_q      <= gap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    busy_d     = busy_q;
    adv_d      = 1'b0;
    cdone_d    = 1'b0;
    to_d       = to_q;
    cnt_d      = cnt_q;
    runs_d     = runs_q;
    ds_d       = ds_q;
    lat_d      = lat_q;
    last_lat_d = last_lat_q;
    gap_d      = gap_q;
    case (state_q)
      S_IDLE: begin
        start_d = 1'b0;
        busy_d  = 1'b0;
        if (rise && ap_idle) begin
          cnt_d   = run_count;
          runs_d  = '0;
          to_d    = 1'b0;
          ds_d    = '0;
          busy_d  = 1'b1;
          start_d = 1'b1;
          lat_d   = 32'd1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (lat_q != '1) lat_d = lat_q + 32'd1;
        if (ap_ready) start_d = 1'b0;
        if (ap_done) begin
          last_lat_d = lat_q;
          runs_d     = runs_inc;
          ds_d       = (ds_q == DS_LAST) ? '0 : ds_q + 1'b1;
          adv_d      = 1'b1;
          if (((cnt_q != '0) && (runs_inc == cnt_q)) || ((cnt_q == '0) && !trig_s2_q)) begin
            cdone_d = 1'b1;
            busy_d  = 1'b0;
            start_d = 1'b0;
            state_d = S_IDLE;
          end else if (GAP_CYCLES == 0) begin
            start_d = 1'b1;
            lat_d   = 32'd1;
          end else begin
            start_d = 1'b0;
            gap_d   = GAP_W'(GAP_CYCLES - 1);
            state_d = S_GAP;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (lat_q == TO_LIM)) begin
          // runs_done and last_latency keep the last good run
          to_d    = 1'b1;
          cdone_d = 1'b1;
          busy_d  = 1'b0;
          start_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        start_d = 1'b0;
        if (gap_q == '0) begin
          start_d = 1'b1;
          lat_d   = 32'd1;
          state_d = S_RUN;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ap_start      = start_q;
  assign busy          = busy_q;
  assign ds_advance    = adv_q;
  assign campaign_done = cdone_q;
  assign timeout       = to_q;
  assign runs_done     = runs_q;
  assign dataset_idx   = ds_q;
  assign last_latency  = last_lat_q;

endmodule

// File: tb/tb_kernel_run_ctrl.sv
// Directed bench for kernel_run_ctrl: one instance with a 4-cycle gap and 50-cycle
// watchdog, one with no gap and no watchdog for the same-cycle ready/done case.
module tb_kernel_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic trig_a, trig_b;
  logic [15:0] rc_a, rc_b;

  logic start_a, adv_a, busy_a, to_a, cd_a;
  logic rdy_a = 1'b0, done_a = 1'b0, idle_a = 1'b1;
  logic [2:0] ds_a;
  logic [15:0] runs_a;
  logic [31:0] lat_a;

  logic start_b, adv_b, busy_b, to_b, cd_b;
  logic rdy_b = 1'b0, done_b = 1'b0, idle_b = 1'b1;
  logic [2:0] ds_b;
  logic [15:0] runs_b;
  logic [31:0] lat_b;

  int checks = 0;
  int errors = 0;

  kernel_run_ctrl #(.RUN_W(16), .DATASET_NUM(8), .GAP_CYCLES(4), .TIMEOUT_CYCLES(50)) u_a (
    .ap_clk(clk), .ap_rst_n(rst_n), .trig(trig_a), .run_count(rc_a),
    .ap_start(start_a), .ap_ready(rdy_a), .ap_done(done_a), .ap_idle(idle_a),
    .dataset_idx(ds_a), .ds_advance(adv_a), .busy(busy_a), .runs_done(runs_a),
    .last_latency(lat_a), .timeout(to_a), .campaign_done(cd_a));

  kernel_run_ctrl #(.RUN_W(16), .DATASET_NUM(8), .GAP_CYCLES(0), .TIMEOUT_CYCLES(0)) u_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .trig(trig_b), .run_count(rc_b),
    .ap_start(start_b), .ap_ready(rdy_b), .ap_done(done_b), .ap_idle(idle_b),
    .dataset_idx(ds_b), .ds_advance(adv_b), .busy(busy_b), .runs_done(runs_b),
    .last_latency(lat_b), .timeout(to_b), .campaign_done(cd_b));

  // Kernel models: start seen in cycle s gives ready at s+RDY and done at s+DONE.
  int rdy_dly_a = 1, done_dly_a = 10, t_a = 0, t_b = 0;
  bit never_a = 0, abort_a = 0, hold_a = 0, act_a = 0, act_b = 0;

  always @(negedge clk) begin
    if (!rst_n || abort_a) begin act_a = 0; t_a = 0; end
    else if (!act_a && start_a) begin act_a = 1; t_a = 0; end
    else if (act_a) t_a++;
    rdy_a  = act_a && (t_a == rdy_dly_a);
    done_a = act_a && !never_a && (t_a == done_dly_a);
    if (done_a) act_a = 0;
    idle_a = !act_a && !hold_a;
  end

  always @(negedge clk) begin
    if (!rst_n) begin act_b = 0; t_b = 0; end
    else if (!act_b && start_b) begin act_b = 1; t_b = 0; end
    else if (act_b) t_b++;
    rdy_b  = act_b && (t_b == 0);
    done_b = act_b && (t_b == 0);
    if (done_b) act_b = 0;
    idle_b = !act_b;
  end

  int cyc = 0, rises_a = 0, bad_w_a = 0, advs_a = 0, cds_a = 0, last_gap_a = -1, adv_cyc_a = 0, w_a = 0;
  bit prev_a = 0;
  int ds_log[$];

  always @(negedge clk) begin
    cyc++;
    if (start_a && !prev_a) begin rises_a++; last_gap_a = cyc - adv_cyc_a; end
    if (start_a) w_a++;
    else begin
      if (prev_a && w_a != 2) bad_w_a++;
      w_a = 0;
    end
    if (adv_a) begin advs_a++; adv_cyc_a = cyc; ds_log.push_back(int'(ds_a)); end
    if (cd_a) cds_a++;
    prev_a = start_a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic check_reset_a(input string pfx);
    chk({pfx, "_ap_start"}, start_a, 0);
    chk({pfx, "_busy"}, busy_a, 0);
    chk({pfx, "_ds_advance"}, adv_a, 0);
    chk({pfx, "_campaign_done"}, cd_a, 0);
    chk({pfx, "_timeout"}, to_a, 0);
    chk({pfx, "_dataset_idx"}, ds_a, 0);
    chk({pfx, "_runs_done"}, runs_a, 0);
    chk({pfx, "_last_latency"}, lat_a, 0);
  endtask

  // Bounded wait for the end of a campaign; busy must fall with campaign_done high.
  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy_a && n < budget) begin step(); n++; end
    chk({tag, "_busy_fell"}, busy_a, 0);
    chk({tag, "_cdone_with_busy_fall"}, cd_a, 1);
  endtask

  int r0, c0, b0, a0, l0, n;
  int exp_ds[10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};

  initial begin
    rst_n = 0; trig_a = 0; trig_b = 0; rc_a = 0; rc_b = 0;
    #1;
    check_reset_a("rst0");
    chk("rst0_b_ap_start", start_b, 0);
    chk("rst0_b_runs_done", runs_b, 0);
    step(3);
    rst_n = 1;
    step(2);

    // three counted runs, trig dropped mid-campaign
    rc_a = 16'd3; r0 = rises_a; c0 = cds_a; b0 = bad_w_a;
    trig_a = 1;
    step(2);
    chk("t1_start_not_early", start_a, 0);
    step();
    chk("t1_start_at_k2", start_a, 1);
    chk("t1_busy_at_k2", busy_a, 1);
    trig_a = 0;
    wait_idle(200, "t1");
    step();
    chk("t1_cdone_one_cycle", cd_a, 0);
    chk("t1_start_count", rises_a - r0, 3);
    chk("t1_start_width", bad_w_a - b0, 0);
    chk("t1_cdone_count", cds_a - c0, 1);
    chk("t1_last_latency", lat_a, 11);
    chk("t1_runs_done", runs_a, 3);
    chk("t1_dataset_idx", ds_a, 3);
    chk("t1_gap", last_gap_a, 4);
    chk("t1_start_low", start_a, 0);

    // dataset wrap over ten runs; a retrigger while busy is ignored
    rc_a = 16'd10; r0 = rises_a;
    trig_a = 1;
    step(3);
    chk("t2_start", start_a, 1);
    chk("t2_runs_cleared", runs_a, 0);
    chk("t2_ds_cleared", ds_a, 0);
    a0 = advs_a; l0 = ds_log.size();
    step(5); trig_a = 0;
    step(5); trig_a = 1;
    wait_idle(400, "t2");
    chk("t2_adv_count", advs_a - a0, 10);
    for (int i = 0; i < 10; i++) begin
      if (l0 + i < ds_log.size()) chk($sformatf("t2_ds_seq%0d", i), ds_log[l0 + i], exp_ds[i]);
      else chk($sformatf("t2_ds_seq%0d_missing", i), 32'hFFFF_FFFF, exp_ds[i]);
    end
    chk("t2_runs_done", runs_a, 10);
    chk("t2_dataset_idx", ds_a, 2);
    step(10);
    chk("t2_no_restart_busy", busy_a, 0);
    chk("t2_no_restart_starts", rises_a - r0, 10);

    // continuous mode, trig dropped during run 5
    trig_a = 0; step(3);
    rc_a = 16'd0; r0 = rises_a; c0 = cds_a;
    trig_a = 1;
    n = 0;
    while ((rises_a - r0) < 5 && n < 300) begin step(); n++; end
    chk("t3_reached_run5", rises_a - r0, 5);
    step(3);
    trig_a = 0;
    wait_idle(100, "t3");
    chk("t3_runs_done", runs_a, 5);
    chk("t3_cdone_count", cds_a - c0, 1);
    chk("t3_last_latency", lat_a, 11);
    step(20);
    chk("t3_no_run6", rises_a - r0, 5);
    chk("t3_idle_busy", busy_a, 0);

    // watchdog: kernel never finishes
    never_a = 1; rc_a = 16'd1;
    trig_a = 1;
    step(3);
    chk("t4_start", start_a, 1);
    step(49);
    chk("t4_no_timeout_cycle50", to_a, 0);
    chk("t4_busy_cycle50", busy_a, 1);
    step();
    chk("t4_timeout", to_a, 1);
    chk("t4_busy_low", busy_a, 0);
    chk("t4_start_low", start_a, 0);
    chk("t4_cdone", cd_a, 1);
    chk("t4_runs_unchanged", runs_a, 0);
    chk("t4_latency_unchanged", lat_a, 11);
    abort_a = 1; trig_a = 0;
    step(4);
    abort_a = 0; never_a = 0;
    trig_a = 1;
    step(3);
    chk("t4_retrig_start", start_a, 1);
    chk("t4_timeout_cleared", to_a, 0);
    wait_idle(100, "t4");
    chk("t4_runs_after_retrig", runs_a, 1);

    // same-cycle ready and done, no gap
    rc_b = 16'd2;
    trig_b = 1;
    step(3);
    chk("t5_start_first", start_b, 1);
    step();
    chk("t5_start_second", start_b, 1);
    chk("t5_runs_one", runs_b, 1);
    chk("t5_latency", lat_b, 1);
    step();
    chk("t5_runs_two", runs_b, 2);
    chk("t5_start_low", start_b, 0);
    chk("t5_cdone", cd_b, 1);
    chk("t5_busy_low", busy_b, 0);

    // asynchronous reset mid-run, then a rise with the kernel busy
    trig_a = 0; rc_a = 16'd3;
    step(3);
    trig_a = 1;
    step(8);
    chk("t6_in_run", busy_a, 1);
    #2;
    rst_n = 0; hold_a = 1; trig_a = 0;
    #1;
    check_reset_a("t6_async");
    step(2);
    rst_n = 1;
    r0 = rises_a;
    trig_a = 1;
    step(10);
    chk("t6_rise_dropped_starts", rises_a - r0, 0);
    chk("t6_rise_dropped_busy", busy_a, 0);
    hold_a = 0;
    step(5);
    chk("t6_no_late_start", start_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete, observed time %0t", $time);
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/kernel_run_ctrl.md
# kernel_run_ctrl

Run sequencer for an HLS kernel and its `kernel_ram` input banks in the power-measurement wrapper. It replaces the free-running VIO-to-`ap_start` flop chain:
- synchronises the VIO trigger;
- launches a programmed number of kernel invocations with the `ap_start`/`ap_ready`/`ap_done` block protocol;
- inserts a fixed idle gap between runs;
- advances the dataset index fed to the RAM banks;
- records per-run latency, with a watchdog timeout.

## Interface

Parameters:
- `RUN_W`, 16: width of `run_count` and `runs_done`.
- `DATASET_NUM`, 8: number of datasets; `dataset_idx` wraps at this value.
- `GAP_CYCLES`, 4: idle cycles with `ap_start` low between `ap_done` and the next `ap_start`. 0 is legal.
- `TIMEOUT_CYCLES`, 1000000: watchdog limit in cycles per run. 0 disables the watchdog.

Ports:
- `ap_clk`  in  1  sole clock.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `trig`  in  1  VIO probe, asynchronous to `ap_clk`. A rising edge starts a campaign.
- `run_count`  in  RUN_W  runs per campaign, sampled at campaign start. 0 means continuous running while `trig` stays high.
- `ap_start`  out  1  kernel start.
- `ap_ready`  in  1  kernel accepted start.
- `ap_done`  in  1  kernel finished, one-cycle pulse.
- `ap_idle`  in  1  kernel idle.
- `dataset_idx`  out  clog2(DATASET_NUM)  current dataset for the RAM banks.
- `ds_advance`  out  1  one-cycle pulse when `dataset_idx` changes.
- `busy`  out  1  campaign in progress.
- `runs_done`  out  RUN_W  completed runs in the current or last campaign.
- `last_latency`  out  32  cycles of the most recent completed run.
- `timeout`  out  1  sticky watchdog flag.
- `campaign_done`  out  1  one-cycle pulse at campaign end.

## Operation

- **Trigger path:** 2-flop synchroniser on `trig`, plus a third flop for edge detect. `rise = s2 & ~s3`.
- **FSM states:** IDLE, RUN, GAP.
- **IDLE:**
  - Outputs: `ap_start` 0, `busy` 0.
  - On `rise` with `ap_idle` = 1: latch `run_count`; clear `runs_done`, `timeout` and `dataset_idx` to 0; set `busy` 1; go to RUN.
  - `rise` while `ap_idle` = 0 is dropped.
- **RUN:**
  - `ap_start` is 1 from RUN entry through the cycle in which `ap_ready` = 1, then 0 for the rest of RUN.
  - The latency counter loads 1 on RUN entry and increments each cycle, saturating at 2^32-1.
  - On `ap_done`:
    - `last_latency` <= counter.
    - `runs_done` += 1.
    - `dataset_idx` <= (`dataset_idx` + 1) mod DATASET_NUM, and `ds_advance` pulses.
    - Next state:
      - If latched count ≠ 0 and `runs_done`+1 == latched count, pulse `campaign_done` and go to IDLE.
      - Else if latched count == 0 and synchronised `trig` (s2) == 0, pulse `campaign_done` and go to IDLE.
      - Else if GAP_CYCLES == 0, restart RUN directly.
      - Otherwise go to GAP.
- **GAP:** count GAP_CYCLES cycles with `ap_start` = 0, then go to RUN.
- **`ap_ready` and `ap_done` in the same cycle:** both are processed. `ap_start` drops and the run completes.
- **Watchdog:** in RUN, if TIMEOUT_CYCLES ≠ 0 and counter == TIMEOUT_CYCLES with no `ap_done` that cycle:
  - set `timeout` 1 and pulse `campaign_done`;
  - go to IDLE with `ap_start` 0;
  - `runs_done` and `last_latency` are unchanged.
- **Trigger during a campaign:**
  - `rise` while busy is ignored.
  - `trig` falling mid-campaign with latched count ≠ 0 is ignored.
  - With continuous mode, `trig` falling stops the campaign at the next `ap_done`. A run in flight is never aborted.
- **Wrap rules:**
  - `runs_done` wraps modulo 2^RUN_W in continuous mode.
  - `dataset_idx` wraps DATASET_NUM-1 → 0.
- **Reset:** asynchronous and effective mid-run. All state clears immediately; the kernel is reset by its own `ap_rst`.

## Timing

- **Reset values:**
  - `ap_start`, `busy`, `ds_advance`, `campaign_done`, `timeout`: 0.
  - `dataset_idx`, `runs_done`, `last_latency`: 0.
  - FSM: IDLE.
- **All outputs are registered.**
- **`trig` to `ap_start`:** if `trig` is first sampled high at edge k, `ap_start` and `busy` go high after edge k+2.
- **`ap_ready` to `ap_start` low:** `ap_ready` high in cycle n gives `ap_start` low from cycle n+1.
- **`ap_done` in cycle n:**
  - `last_latency`, `runs_done`, `dataset_idx`, `ds_advance` and `campaign_done` update after edge n.
  - The next `ap_start` is high in cycle n+1+GAP_CYCLES.
- **Latency definition:** cycles from the first `ap_start`-high cycle to the `ap_done` cycle, inclusive. A kernel asserting `ap_done` in the same cycle as the first `ap_start` gives latency 1.
- **`busy`:** falls in the cycle `campaign_done` is high.

## Test plan

- **Three fixed runs:** `run_count`=3, GAP_CYCLES=4, kernel model with `ap_ready` 1 cycle after start and `ap_done` 10 cycles after start.
  - Exactly 3 `ap_start` assertions, each 2 cycles wide.
  - `last_latency`=11; `runs_done`=3; `dataset_idx`=3.
  - One `campaign_done` pulse; `busy` low afterwards.
- **Dataset wrap:** `run_count`=10, DATASET_NUM=8.
  - `dataset_idx` sequence 1..7,0,1,2.
  - 10 `ds_advance` pulses.
- **Continuous mode:** `run_count`=0; drop `trig` in the middle of run 5.
  - Run 5 completes; no run 6.
  - `runs_done`=5; `campaign_done` pulses.
- **Watchdog:** TIMEOUT_CYCLES=50; kernel never asserts `ap_done`.
  - `timeout`=1 after exactly 50 RUN cycles; `ap_start` 0; FSM back in IDLE.
  - Next `rise` clears `timeout`.
- **Same-cycle ready/done:** `ap_ready` and `ap_done` both in the first `ap_start` cycle, GAP_CYCLES=0, `run_count`=2.
  - `last_latency`=1; second `ap_start` in the next cycle; `runs_done`=2.
- **Reset and ignored trigger:** assert `ap_rst_n` low mid-RUN.
  - All outputs reach reset values without a clock edge.
  - A `trig` rise with `ap_idle`=0 after reset produces no `ap_start`.
